// File: rtl/sysctrl_gen.sv
// rtl/sysctrl_gen.sv - MCU system-control slave: SPI byte command decoder, config bank, interrupt latch
//
// Decodes the byte stream handed over by the MCU SPI deserialiser. A byte flagged
// with data_in_start is a command; the bytes that follow are its payload and are
// numbered 1, 2, ... (the index saturates at 15). Each payload byte may update
// the LEDs, RGB colour, config bank or interrupt state, and it always produces a
// registered reply byte on data_out in the cycle after the strobe.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset (release is expected synchronous)
//   data_in_strobe  one-cycle pulse, data_in valid
//   data_in_start   qualifies the strobe: data_in is a command byte
//   data_in         received byte
//   data_out        registered reply byte
//   int_in          interrupt sources (level); rising edges latched, bit 0 unused
//   int_out_n       low while any interrupt is pending or coldboot is set
//   int_ack         one-cycle pulse of the acknowledged mask
//   buttons         board buttons, readable through command 3
//   leds            MCU-driven LEDs
//   color           RGB value for the ws2812 driver
//   cfg             flattened config bank, slot k in bits [8k+7:8k]
//   cfg_strobe      one-cycle pulse after a config write
//   cfg_index       slot written by the most recent config write
module sysctrl_gen #(
    parameter logic [7:0]            CORE_ID     = 8'h00,
    parameter int                    NUM_VARS    = 16,
    parameter logic [7:0]            ID_BASE     = 8'h41,
    parameter logic [NUM_VARS*8-1:0] CFG_DEFAULT = '0,
    parameter int                    INT_W       = 8,
    parameter int                    BTN_W       = 2,
    parameter int                    LED_W       = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_in_strobe,
    input  logic                  data_in_start,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic [INT_W-1:0]      int_in,
    output logic                  int_out_n,
    output logic [INT_W-1:0]      int_ack,
    input  logic [BTN_W-1:0]      buttons,
    output logic [LED_W-1:0]      leds,
    output logic [23:0]           color,
    output logic [NUM_VARS*8-1:0] cfg,
    output logic                  cfg_strobe,
    output logic [5:0]            cfg_index
);

    localparam logic [7:0] CMD_STATUS = 8'd0;
    localparam logic [7:0] CMD_LEDS   = 8'd1;
    localparam logic [7:0] CMD_COLOR  = 8'd2;
    localparam logic [7:0] CMD_BTNS   = 8'd3;
    localparam logic [7:0] CMD_CFG_WR = 8'd4;
    localparam logic [7:0] CMD_IRQ    = 8'd5;
    localparam logic [7:0] CMD_CFG_RD = 8'd6;

    localparam logic [3:0] IDX_MAX  = 4'd15;
    localparam logic [7:0] NV8      = 8'(NUM_VARS);
    localparam logic [7:0] INT_W8   = 8'(INT_W);

    // Bit 0 is the coldboot position and never latches an external edge.
    localparam logic [INT_W-1:0] IRQ_MASK = {{(INT_W-1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [3:0]       state;      // 0 = idle, else index of the next payload byte
    logic [7:0]       command;
    logic [7:0]       var_id;     // id latched by the first payload byte of CMD4/CMD6
    logic [INT_W-1:0] pend;
    logic             coldboot;
    logic [INT_W-1:0] int_prev;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [3:0]            state_nx;
    logic [7:0]            command_nx;
    logic [7:0]            var_id_nx;
    logic [7:0]            data_out_nx;
    logic [LED_W-1:0]      leds_nx;
    logic [23:0]           color_nx;
    logic [NUM_VARS*8-1:0] cfg_nx;
    logic                  cfg_strobe_nx;
    logic [5:0]            cfg_index_nx;
    logic [INT_W-1:0]      int_ack_nx;
    logic [INT_W-1:0]      clear_mask;
    logic [INT_W-1:0]      pend_nx;
    logic                  coldboot_nx;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic             cmd_byte;
    logic             payload_byte;
    logic [7:0]       slot;
    logic             slot_ok;
    logic [7:0]       slot_val;
    logic [7:0]       status_val;
    logic [7:0]       din_rev;
    logic [INT_W-1:0] irq_view;
    logic [INT_W-1:0] rise;

    assign cmd_byte     = data_in_strobe & data_in_start;
    assign payload_byte = data_in_strobe & ~data_in_start & (state != 4'd0);

    // Unsigned 8-bit subtraction: ids below ID_BASE wrap to large values and
    // therefore fall out of range along with ids past the end of the bank.
    assign slot    = var_id - ID_BASE;
    assign slot_ok = slot < NV8;

    always_comb begin
        slot_val = 8'h00;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (slot == 8'(k)) begin
                slot_val = cfg[8*k +: 8];
            end
        end
    end

    always_comb begin
        case (state)
            4'd1:    status_val = 8'h5C;
            4'd2:    status_val = 8'h42;
            4'd3:    status_val = CORE_ID;
            4'd4:    status_val = NV8;
            4'd5:    status_val = INT_W8;
            default: status_val = 8'h00;
        endcase
    end

    // The MCU sends colour bytes LSB-first relative to the ws2812 bit order.
    always_comb begin
        din_rev = 8'h00;
        for (int b = 0; b < 8; b++) begin
            din_rev[b] = data_in[7-b];
        end
    end

    assign irq_view = {pend[INT_W-1:1], coldboot};
    assign rise     = int_in & ~int_prev & IRQ_MASK;

    // ------------------------------------------------------------------
    // Byte handling
    // ------------------------------------------------------------------
    always_comb begin
        state_nx      = state;
        command_nx    = command;
        var_id_nx     = var_id;
        data_out_nx   = data_out;
        leds_nx       = leds;
        color_nx      = color;
        cfg_nx        = cfg;
        cfg_strobe_nx = 1'b0;
        cfg_index_nx  = cfg_index;
        int_ack_nx    = '0;
        clear_mask    = '0;

        if (cmd_byte) begin
            // A start byte always opens a new command, even mid-payload.
            command_nx = data_in;
            state_nx   = 4'd1;
        end else if (payload_byte) begin
            if (state != IDX_MAX) begin
                state_nx = state + 4'd1;
            end
            data_out_nx = 8'h00;

            case (command)
                CMD_STATUS: begin
                    data_out_nx = status_val;
                end

                CMD_LEDS: begin
                    if (state == 4'd1) begin
                        leds_nx = data_in[LED_W-1:0];
                    end
                end

                CMD_COLOR: begin
                    case (state)
                        4'd1:    color_nx[15:8]  = din_rev;
                        4'd2:    color_nx[7:0]   = din_rev;
                        4'd3:    color_nx[23:16] = din_rev;
                        default: ;
                    endcase
                end

                CMD_BTNS: begin
                    data_out_nx = 8'(buttons);
                end

                CMD_CFG_WR: begin
                    if (state == 4'd1) begin
                        var_id_nx = data_in;
                    end else if ((state == 4'd2) && slot_ok) begin
                        for (int k = 0; k < NUM_VARS; k++) begin
                            if (slot == 8'(k)) begin
                                cfg_nx[8*k +: 8] = data_in;
                            end
                        end
                        cfg_strobe_nx = 1'b1;
                        cfg_index_nx  = slot[5:0];
                    end
                end

                CMD_IRQ: begin
                    // Reply reflects the state before this byte's acknowledge.
                    data_out_nx = 8'(irq_view);
                    if (state == 4'd1) begin
                        int_ack_nx = data_in[INT_W-1:0];
                        clear_mask = data_in[INT_W-1:0];
                    end
                end

                CMD_CFG_RD: begin
                    if (state == 4'd1) begin
                        var_id_nx = data_in;
                    end else if ((state == 4'd2) && slot_ok) begin
                        data_out_nx = slot_val;
                    end
                end

                default: ;
            endcase
        end

        // A new edge in the same cycle as its acknowledge stays pending.
        pend_nx     = (pend & ~clear_mask) | rise;
        coldboot_nx = coldboot & ~clear_mask[0];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= 4'd0;
            command    <= 8'h00;
            var_id     <= 8'h00;
            data_out   <= 8'h00;
            leds       <= '0;
            color      <= 24'h000000;
            cfg        <= CFG_DEFAULT;
            cfg_strobe <= 1'b0;
            cfg_index  <= 6'd0;
            int_ack    <= '0;
            pend       <= '0;
            coldboot   <= 1'b1;
            int_prev   <= '0;
        end else begin
            state      <= state_nx;
            command    <= command_nx;
            var_id     <= var_id_nx;
            data_out   <= data_out_nx;
            leds       <= leds_nx;
            color      <= color_nx;
            cfg        <= cfg_nx;
            cfg_strobe <= cfg_strobe_nx;
            cfg_index  <= cfg_index_nx;
            int_ack    <= int_ack_nx;
            pend       <= pend_nx;
            coldboot   <= coldboot_nx;
            int_prev   <= int_in;
        end
    end

    assign int_out_n = ~((|pend) | coldboot);

endmodule

// File: tb/tb_sysctrl_gen.sv
// tb/tb_sysctrl_gen.sv - self-checking bench for sysctrl_gen with a behavioural reference model
module tb_sysctrl_gen;

    localparam logic [7:0]       CORE_ID_T = 8'h07;
    localparam int               NV        = 16;
    localparam logic [7:0]       IB        = 8'h41;
    localparam int               IW        = 8;
    localparam int               BW        = 2;
    localparam int               LW        = 2;
    localparam logic [NV*8-1:0]  CFG_DEF   = 128'h0F0E0D0C0B0A09080706050403020100;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              data_in_strobe;
    logic              data_in_start;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [IW-1:0]     int_in;
    logic              int_out_n;
    logic [IW-1:0]     int_ack;
    logic [BW-1:0]     buttons;
    logic [LW-1:0]     leds;
    logic [23:0]       color;
    logic [NV*8-1:0]   cfg;
    logic              cfg_strobe;
    logic [5:0]        cfg_index;

    sysctrl_gen #(
        .CORE_ID(CORE_ID_T), .NUM_VARS(NV), .ID_BASE(IB), .CFG_DEFAULT(CFG_DEF),
        .INT_W(IW), .BTN_W(BW), .LED_W(LW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
        .data_out(data_out), .int_in(int_in), .int_out_n(int_out_n), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .cfg(cfg),
        .cfg_strobe(cfg_strobe), .cfg_index(cfg_index)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    logic [7:0]    m_cmd;
    int            m_idx;          // 0 = no command open
    logic [7:0]    m_id;
    logic [7:0]    m_cfg [NV];
    logic [7:0]    m_rgb [1:3];    // colour bytes in payload order
    logic [IW-1:0] m_pend;
    logic          m_coldboot;
    logic [IW-1:0] m_prev;
    logic [7:0]    exp_dout;
    logic [LW-1:0] exp_leds;
    logic          exp_strobe;
    logic [5:0]    exp_index;
    logic [IW-1:0] exp_ack;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] status_byte(input int i);
        case (i)
            1:       return 8'h5C;
            2:       return 8'h42;
            3:       return CORE_ID_T;
            4:       return 8'(NV);
            5:       return 8'(IW);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [NV*8-1:0] cfg_image();
        logic [NV*8-1:0] r;
        for (int k = 0; k < NV; k++) r[8*k +: 8] = m_cfg[k];
        return r;
    endfunction

    task automatic model_reset();
        logic [NV*8-1:0] d;
        d = CFG_DEF;
        m_cmd = 8'h00; m_idx = 0; m_id = 8'h00;
        for (int k = 0; k < NV; k++) m_cfg[k] = d[8*k +: 8];
        for (int k = 1; k <= 3; k++) m_rgb[k] = 8'h00;
        m_pend = '0; m_coldboot = 1'b1; m_prev = '0;
        exp_dout = 8'h00; exp_leds = '0; exp_strobe = 1'b0; exp_index = 6'd0; exp_ack = '0;
    endtask

    // Computes what the outputs must be after the next clock edge for the inputs now applied.
    task automatic model_step();
        logic [IW-1:0] rise, clr, view;
        logic [7:0]    s, rv;
        int            i;
        exp_strobe = 1'b0;
        exp_ack    = '0;
        clr        = '0;
        rise       = int_in & ~m_prev;
        rise[0]    = 1'b0;
        m_prev     = int_in;
        view       = {m_pend[IW-1:1], m_coldboot};
        if (data_in_strobe && data_in_start) begin
            m_cmd = data_in;
            m_idx = 1;
        end else if (data_in_strobe && m_idx != 0) begin
            i = m_idx;
            if (m_idx < 15) m_idx = m_idx + 1;
            exp_dout = 8'h00;
            s = m_id - IB;
            case (m_cmd)
                8'd0: exp_dout = status_byte(i);
                8'd1: if (i == 1) exp_leds = data_in[LW-1:0];
                8'd2: begin
                    rv = {<<{data_in}};
                    if (i >= 1 && i <= 3) m_rgb[i] = rv;
                end
                8'd3: exp_dout = 8'(buttons);
                8'd4: begin
                    if (i == 1) m_id = data_in;
                    else if (i == 2 && s < NV) begin
                        m_cfg[s[3:0]] = data_in;
                        exp_strobe = 1'b1;
                        exp_index  = s[5:0];
                    end
                end
                8'd5: begin
                    exp_dout = 8'(view);
                    if (i == 1) begin
                        exp_ack = data_in[IW-1:0];
                        clr     = data_in[IW-1:0];
                    end
                end
                8'd6: begin
                    if (i == 1) m_id = data_in;
                    else if (i == 2 && s < NV) exp_dout = m_cfg[s[3:0]];
                end
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | rise;
        if (clr[0]) m_coldboot = 1'b0;
    endtask

    // Drive one cycle of inputs; returns just after the following falling edge.
    task automatic tick(input logic stb, input logic st, input logic [7:0] d);
        data_in_strobe = stb;
        data_in_start  = st;
        data_in        = d;
        if (reset_n) model_step();
        else model_reset();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_out",   data_out,   exp_dout);
            chk("leds",       leds,       exp_leds);
            chk("color",      color,      {m_rgb[3], m_rgb[1], m_rgb[2]});
            chk("cfg",        cfg,        cfg_image());
            chk("cfg_strobe", cfg_strobe, exp_strobe);
            chk("cfg_index",  cfg_index,  exp_index);
            chk("int_ack",    int_ack,    exp_ack);
            chk("int_out_n",  int_out_n,  !((|m_pend) || m_coldboot));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [NV*8-1:0] cfg_after;
    logic [7:0]      d8;
    logic [7:0]      c8;
    int              n;
    logic [7:0]      stat_exp [1:5];

    initial begin
        reset_n = 1'b0; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = 8'h00;
        int_in = '0; buttons = '0;
        model_reset();
        #1 cmp_en = 1'b1;
        tick(0, 0, 8'h00);
        tick(0, 0, 8'h00);

        // Reset state
        chk("rst data_out", data_out, 8'h00);
        chk("rst leds", leds, 2'b00);
        chk("rst color", color, 24'h000000);
        chk("rst cfg", cfg, CFG_DEF);
        chk("rst cfg_strobe", cfg_strobe, 1'b0);
        chk("rst cfg_index", cfg_index, 6'd0);
        chk("rst int_ack", int_ack, 8'h00);
        chk("rst int_out_n", int_out_n, 1'b0);
        reset_n = 1'b1;

        // Payload strobe with no command open is ignored
        tick(1, 0, 8'hAA);
        chk("idle strobe data_out", data_out, 8'h00);

        // Status command
        stat_exp[1] = 8'h5C; stat_exp[2] = 8'h42; stat_exp[3] = 8'h07;
        stat_exp[4] = 8'h10; stat_exp[5] = 8'h08;
        tick(1, 1, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            tick(1, 0, 8'($urandom));
            chk("status byte", data_out, stat_exp[k]);
        end
        tick(1, 0, 8'h33);
        chk("status idx6", data_out, 8'h00);
        chk("coldboot int_out_n", int_out_n, 1'b0);

        // Config write 'C' <- 7F
        cfg_after = CFG_DEF;
        cfg_after[23:16] = 8'h7F;
        tick(1, 1, 8'h04); tick(1, 0, 8'h43); tick(1, 0, 8'h7F);
        chk("cfg write", cfg, cfg_after);
        chk("cfg_strobe pulse", cfg_strobe, 1'b1);
        chk("cfg_index", cfg_index, 6'd2);
        tick(0, 0, 8'h00);
        chk("cfg_strobe drop", cfg_strobe, 1'b0);

        // Config read 'C'
        tick(1, 1, 8'h06); tick(1, 0, 8'h43);
        chk("cfg rd idx1", data_out, 8'h00);
        tick(1, 0, 8'h00);
        chk("cfg rd C", data_out, 8'h7F);

        // Out-of-range writes: id below base and id one past the bank
        tick(1, 1, 8'h04); tick(1, 0, 8'h20); tick(1, 0, 8'h55);
        chk("oor low strobe", cfg_strobe, 1'b0);
        tick(1, 1, 8'h04); tick(1, 0, 8'h51); tick(1, 0, 8'h55);
        chk("oor high strobe", cfg_strobe, 1'b0);
        chk("oor cfg", cfg, cfg_after);
        tick(1, 1, 8'h06); tick(1, 0, 8'h20); tick(1, 0, 8'h00);
        chk("oor low rd", data_out, 8'h00);
        tick(1, 1, 8'h06); tick(1, 0, 8'h51); tick(1, 0, 8'h00);
        chk("oor high rd", data_out, 8'h00);
        tick(1, 1, 8'h06); tick(1, 0, 8'h50); tick(1, 0, 8'h00);
        chk("last slot rd", data_out, 8'h0F);

        // Interrupt 3 rises and stays high
        int_in = 8'h08;
        repeat (100) tick(0, 0, 8'h00);
        tick(1, 1, 8'h05); tick(1, 0, 8'h08);
        chk("irq read", data_out, 8'h09);
        chk("irq ack", int_ack, 8'h08);
        tick(0, 0, 8'h00);
        chk("irq ack drop", int_ack, 8'h00);
        tick(1, 1, 8'h05); tick(1, 0, 8'h01);
        chk("irq read after ack", data_out, 8'h01);
        chk("coldboot ack", int_out_n, 1'b1);
        int_in = 8'h00;

        // Edge arriving together with its acknowledge stays pending
        tick(1, 1, 8'h05);
        int_in = 8'h04;
        tick(1, 0, 8'h04);
        chk("set-wins ack", int_ack, 8'h04);
        chk("set-wins int_out_n", int_out_n, 1'b0);
        tick(1, 0, 8'h00);
        chk("set-wins read", data_out, 8'h04);
        tick(1, 1, 8'h05); tick(1, 0, 8'h04);
        chk("irq cleared", int_out_n, 1'b1);
        int_in = 8'h00;

        // Colour, with a restart mid-command
        tick(1, 1, 8'h02); tick(1, 0, 8'h01); tick(1, 0, 8'h80); tick(1, 0, 8'hFF);
        chk("color", color, 24'hFF8001);
        tick(1, 1, 8'h02); tick(1, 0, 8'h0F);
        tick(1, 1, 8'h02); tick(1, 0, 8'h03); tick(1, 0, 8'hC0); tick(1, 0, 8'h0F);
        chk("color restart", color, 24'hF0C003);

        // LEDs and buttons
        tick(1, 1, 8'h01); tick(1, 0, 8'hFE);
        chk("leds", leds, 2'b10);
        buttons = 2'b11;
        tick(1, 1, 8'h03); tick(1, 0, 8'h00);
        chk("buttons 3", data_out, 8'h03);
        buttons = 2'b01;
        tick(1, 0, 8'h00);
        chk("buttons 1", data_out, 8'h01);

        // Asynchronous reset in the middle of a config write
        tick(1, 1, 8'h04); tick(1, 0, 8'h44);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async rst cfg", cfg, CFG_DEF);
        chk("async rst color", color, 24'h000000);
        chk("async rst leds", leds, 2'b00);
        chk("async rst int_out_n", int_out_n, 1'b0);
        tick(0, 0, 8'h00);
        reset_n = 1'b1;
        tick(1, 0, 8'h55);
        chk("post rst ignored", cfg, CFG_DEF);
        chk("post rst strobe", cfg_strobe, 1'b0);

        // Randomized command frames
        for (int f = 0; f < 60; f++) begin
            c8 = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) int_in = int_in ^ 8'($urandom);
            buttons = 2'($urandom);
            tick(1, 1, c8);
            n = $urandom_range(0, 17);
            for (int b = 0; b < n; b++) begin
                d8 = 8'($urandom);
                if ((c8 == 8'd4 || c8 == 8'd6) && b == 0)
                    d8 = 8'(int'(IB) + int'($urandom_range(0, 19)) - 2);
                if ($urandom_range(0, 4) == 0) int_in = 8'($urandom);
                buttons = 2'($urandom);
                tick(1, 0, d8);
                if ($urandom_range(0, 3) == 0) tick(0, 1'($urandom), 8'($urandom));
            end
        end
        tick(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
